// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : MEM-stage access controller in front of a word-only data
//                memory with a registered 1-cycle read. Sizes and extends
//                byte/half/word loads and performs SB/SH as a 2-cycle
//                read-modify-write, stalling the pipeline while busy.
//                Optional feature macro: MISALIGN_TRAP_EN (drop misaligned
//                or reserved-size requests and pulse misalign_err).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int WORD_AW = 10
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        misalign_err,
  output logic        MEMRead,
  output logic        MEMWrite,
  output logic [31:0] ADDR,
  output logic [31:0] WD,
  input  logic [31:0] RD
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LD_WAIT   = 2'd1,
    ST_RMW_MERGE = 2'd2
  } state_t;

  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_WORD = 2'b10;
  localparam logic [1:0] c_SZ_RSVD = 2'b11;

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_off;
  logic [1:0]           r_size;
  logic                 r_unsigned;
  logic [WORD_AW-1:0]   r_waddr;
  logic [15:0]          r_wdata;

  logic                 w_trap;
  logic [1:0]           w_eff_size;
  logic [1:0]           w_eff_off;
  logic [WORD_AW-1:0]   w_req_waddr;
  logic                 w_word_store;
  logic                 w_issue;
  logic [31:0]          w_rd_shift;
  logic [31:0]          w_load;
  logic [31:0]          w_lane_mask;
  logic [31:0]          w_merge;
  logic                 w_unused_addr;

  // Upper address bits lie beyond the memory and are deliberately ignored.
  assign w_unused_addr = &{1'b0, req_addr[31:WORD_AW+2]};

`ifdef MISALIGN_TRAP_EN
  logic w_misaligned;
  assign w_misaligned = (req_size == c_SZ_RSVD) ||
                        ((req_size == c_SZ_HALF) && req_addr[0]) ||
                        ((req_size == c_SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign w_trap = w_misaligned;
`else
  assign w_trap = 1'b0;
`endif

  // Reserved size behaves as a word; offsets are masked to the access size,
  // which is a no-op for aligned requests and implements the non-trap mode.
  assign w_eff_size   = (req_size == c_SZ_RSVD) ? c_SZ_WORD : req_size;
  assign w_eff_off    = (w_eff_size == c_SZ_BYTE) ? req_addr[1:0] :
                        (w_eff_size == c_SZ_HALF) ? {req_addr[1], 1'b0} : 2'b00;
  assign w_req_waddr  = req_addr[WORD_AW+1:2];
  assign w_word_store = req_write && (w_eff_size == c_SZ_WORD);
  assign w_issue      = (r_state == ST_IDLE) && req_valid && !w_trap && !w_word_store;

  // Lane extraction / merge on the registered read data (little-endian lanes).
  assign w_rd_shift  = RD >> {r_off, 3'b000};
  assign w_lane_mask = ((r_size == c_SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << {r_off, 3'b000};
  assign w_merge     = (RD & ~w_lane_mask) | (({16'h0000, r_wdata} << {r_off, 3'b000}) & w_lane_mask);

  // Size and extend the load result from the current memory read data.
  always_comb begin
    w_load = RD;
    case (r_size)
      c_SZ_BYTE: w_load = {{24{~r_unsigned & w_rd_shift[7]}},  w_rd_shift[7:0]};
      c_SZ_HALF: w_load = {{16{~r_unsigned & w_rd_shift[15]}}, w_rd_shift[15:0]};
      default:   w_load = RD;
    endcase
  end

  // State register; asynchronous reset drops any pending RMW write at once.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request context captured when a two-cycle operation is issued.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_off      <= 2'b00;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= 16'h0000;
    end else if (w_issue) begin
      r_off      <= w_eff_off;
      r_size     <= w_eff_size;
      r_unsigned <= req_unsigned;
      r_waddr    <= w_req_waddr;
      r_wdata    <= req_wdata[15:0];
    end
  end

  // Next-state and output decode; everything idles at zero.
  always_comb begin
    w_next       = r_state;
    stall        = 1'b0;
    load_valid   = 1'b0;
    load_data    = 32'h0000_0000;
    misalign_err = 1'b0;
    MEMRead      = 1'b0;
    MEMWrite     = 1'b0;
    ADDR         = 32'h0000_0000;
    WD           = 32'h0000_0000;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_trap) begin
            misalign_err = 1'b1;
          end else if (w_word_store) begin
            MEMWrite = 1'b1;
            ADDR     = {{(30-WORD_AW){1'b0}}, w_req_waddr, 2'b00};
            WD       = req_wdata;
          end else begin
            MEMRead = 1'b1;
            stall   = 1'b1;
            ADDR    = {{(30-WORD_AW){1'b0}}, w_req_waddr, 2'b00};
            w_next  = req_write ? ST_RMW_MERGE : ST_LD_WAIT;
          end
        end
      end
      ST_LD_WAIT: begin
        load_valid = 1'b1;
        load_data  = w_load;
        w_next     = ST_IDLE;
      end
      ST_RMW_MERGE: begin
        MEMWrite = 1'b1;
        ADDR     = {{(30-WORD_AW){1'b0}}, r_waddr, 2'b00};
        WD       = w_merge;
        w_next   = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
